// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the stereo PWM audio path: default widths, silence level, sample-pair type.
`default_nettype none

package pwm_audio_pkg;

  localparam int PWM_W_DEF    = 8;
  localparam int SAMPLE_W_DEF = 16;

  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  localparam logic [PWM_W_DEF-1:0] MIDSCALE = PWM_W_DEF'(midscale(PWM_W_DEF));

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } sample_pair_t;

endpackage

`default_nettype wire

// File: rtl/stereo_sample_fifo.sv
// Synchronous sample-pair FIFO with registered full/empty flags and occupancy count.
`default_nettype none

module stereo_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // A full FIFO refuses the write even when a pop frees a slot on the same edge.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign fill_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pwm_sample_feeder.sv
// Buffers signed stereo PCM pairs and, once per PWM frame, converts the FIFO head to
// offset-binary duty values for the PWM core.
`default_nettype none

module pwm_sample_feeder import pwm_audio_pkg::*; #(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int PWM_W      = PWM_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          aclr_n,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    atten,
  input  logic                          underrun_clr,
  output logic [PWM_W-1:0]              left_top,
  output logic [PWM_W-1:0]              right_top,
  output logic                          frame_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam logic [PWM_W-1:0]    MID = PWM_W'(midscale(PWM_W));
  localparam logic [SAMPLE_W:0]   RND = (SAMPLE_W+1)'(1) << (SAMPLE_W - PWM_W - 1);

  // Round to nearest, saturate at positive full scale, then flip the MSB for offset binary.
  function automatic logic [PWM_W-1:0] to_duty(input logic signed [SAMPLE_W-1:0] s,
                                                input logic [2:0] sh);
    logic signed [SAMPLE_W-1:0] a;
    logic [SAMPLE_W:0]          r;
    logic [PWM_W-1:0]           d;
    a = s >>> sh;
    r = {a[SAMPLE_W-1], a} + RND;
    if (!r[SAMPLE_W] && r[SAMPLE_W-1]) d = '1;
    else d = PWM_W'(r >> (SAMPLE_W - PWM_W)) ^ MID;
    return d;
  endfunction

  logic [PWM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [PWM_W-1:0]      left_q, left_d, right_q, right_d;
  logic                  tick_q, tick_d, underrun_q, underrun_d;
  logic                  load, fifo_full, fifo_empty;
  logic [2*SAMPLE_W-1:0] head;

  assign load = (frame_cnt_q == '1);

  stereo_sample_fifo #(
    .DATA_W (2*SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .push_i  (in_valid),
    .wdata_i ({in_left, in_right}),
    .pop_i   (load),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q + PWM_W'(1);
    left_d      = left_q;
    right_d     = right_q;
    tick_d      = load;
    underrun_d  = underrun_q;
    if (load && !fifo_empty) begin
      left_d  = to_duty(head[2*SAMPLE_W-1:SAMPLE_W], atten);
      right_d = to_duty(head[SAMPLE_W-1:0], atten);
    end
    if (load && fifo_empty) underrun_d = 1'b1;
    else if (underrun_clr)  underrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      frame_cnt_q <= '0;
      left_q      <= MID;
      right_q     <= MID;
      tick_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      tick_q      <= tick_d;
      underrun_q  <= underrun_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign left_top   = left_q;
  assign right_top  = right_q;
  assign frame_tick = tick_q;
  assign underrun   = underrun_q;

endmodule

`default_nettype wire
